// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor, LSB first.
// One result bit per clock, fixed WIDTH-cycle run.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             s_bit;
  logic             c_nxt;

  // Full-adder slice on the current LSBs and the running carry.
  assign s_bit = a_q[0] ^ b_q[0] ^ c_q;
  assign c_nxt = (a_q[0] & b_q[0])
               | (c_q & (a_q[0] ^ b_q[0]));

  // Next-state and datapath update; outputs are registered.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          c_d     = sub ? 1'b1 : cin;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = c_nxt;
        res_d = {s_bit, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sum_d   = {s_bit, res_q[WIDTH-1:1]};
          cout_d  = c_nxt;
          ovf_d   = c_q ^ c_nxt;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed, random,
// exhaustive 4-bit, start-ignore and reset cases.
module tb_serial_adder;

  localparam int W8 = 8;
  localparam int W4 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [W8-1:0] a8 = '0, b8 = '0;
  logic          busy8, done8, cout8, ovf8;
  logic [W8-1:0] sum8;

  logic          start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
  logic [W4-1:0] a4 = '0, b4 = '0;
  logic          busy4, done4, cout4, ovf4;
  logic [W4-1:0] sum4;

  int n_chk = 0;
  int n_pass = 0;
  logic [9:0] last8 = '0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .start(start8), .sub(sub8),
    .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8),
    .sum(sum8), .cout(cout8),
    .overflow(ovf8)
  );

  serial_adder #(.WIDTH(W4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .start(start4), .sub(sub4),
    .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4),
    .sum(sum4), .cout(cout4),
    .overflow(ovf4)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h",
                  tag, got, exp);
  endtask

  // Returns {ovf, cout, sum} from integer arithmetic.
  function automatic logic [33:0] ref_model(
      input int w, input logic s,
      input logic [31:0] a, input logic [31:0] b,
      input logic ci);
    longint m, ua, ub, full, sa, sb, sr;
    logic co, ov;
    logic [31:0] r;
    m  = longint'(1) << w;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (s) begin
      full = ua - ub + m;
      sr   = sa - sb;
    end else begin
      full = ua + ub + longint'(ci);
      sr   = sa + sb + longint'(ci);
    end
    co = (full >= m);
    r  = 32'(full % m);
    ov = (sr < -(m / 2)) || (sr >= m / 2);
    return {ov, co, r};
  endfunction

  function automatic logic [9:0] exp8(
      input logic s, input logic [7:0] a,
      input logic [7:0] b, input logic ci);
    logic [33:0] r;
    r = ref_model(W8, s, {24'd0, a}, {24'd0, b}, ci);
    return {r[33:32], r[7:0]};
  endfunction

  task automatic op8(input logic s,
                     input logic [7:0] a,
                     input logic [7:0] b,
                     input logic ci,
                     input string tag);
    logic [9:0] e;
    int n;
    e = exp8(s, a, b, ci);
    @(negedge clk);
    start8 = 1'b1; sub8 = s;
    a8 = a; b8 = b; cin8 = ci;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    sub8 = 1'($urandom); cin8 = 1'($urandom);
    check({tag, "_busy"}, 64'(busy8), 64'd1);
    n = 0;
    while (!done8 && n < 4 * W8) begin
      @(negedge clk);
      n++;
      if (n == 3)
        check({tag, "_hold"},
              64'({ovf8, cout8, sum8}), 64'(last8));
    end
    check({tag, "_lat"}, 64'(n), 64'(W8));
    check({tag, "_res"},
          64'({ovf8, cout8, sum8}), 64'(e));
    check({tag, "_bsy0"}, 64'(busy8), 64'd0);
    last8 = e;
    @(negedge clk);
    check({tag, "_pulse"}, 64'(done8), 64'd0);
  endtask

  task automatic op4(input logic [3:0] a,
                     input logic [3:0] b,
                     input logic ci);
    logic [33:0] r;
    int n;
    r = ref_model(W4, 1'b0, {28'd0, a}, {28'd0, b}, ci);
    @(negedge clk);
    start4 = 1'b1; sub4 = 1'b0;
    a4 = a; b4 = b; cin4 = ci;
    @(negedge clk);
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 4 * W4) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("w4_%0h_%0h_%0d", a, b, ci),
          64'({ovf4, cout4, sum4}),
          64'({r[33:32], r[3:0]}));
  endtask

  initial begin
    logic [9:0] e;
    int n, m, hits, done_at;

    #3;
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_done", 64'(done8), 64'd0);
    check("rst_res", 64'({ovf8, cout8, sum8}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op8(1'b0, 8'hFF, 8'h01, 1'b0, "add_ff01");
    op8(1'b0, 8'h7F, 8'h00, 1'b1, "add_7f00");
    op8(1'b1, 8'h05, 8'h07, 1'b0, "sub_0507");
    op8(1'b1, 8'h80, 8'h01, 1'b0, "sub_8001");

    for (int i = 0; i < 60; i++)
      op8(1'($urandom), 8'($urandom), 8'($urandom),
          1'($urandom), $sformatf("rnd%0d", i));

    // start pulses mid-run must be ignored
    e = exp8(1'b0, 8'h5A, 8'h33, 1'b1);
    @(negedge clk);
    start8 = 1'b1; sub8 = 1'b0;
    a8 = 8'h5A; b8 = 8'h33; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 0; hits = 0; done_at = -1;
    while (n < W8) begin
      @(negedge clk);
      n++;
      start8 = (n == 3) || (n == 5);
      if (start8) begin
        a8 = 8'($urandom); b8 = 8'($urandom);
        sub8 = 1'b1;
      end
      if (done8) begin
        hits++;
        done_at = n;
      end
    end
    check("ign_hits", 64'(hits), 64'd1);
    check("ign_lat", 64'(done_at), 64'(W8));
    check("ign_res", 64'({ovf8, cout8, sum8}), 64'(e));
    last8 = e;

    // back-to-back start during DONE
    e = exp8(1'b1, 8'h10, 8'h20, 1'b0);
    start8 = 1'b1; sub8 = 1'b1;
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    check("b2b_busy", 64'(busy8), 64'd1);
    m = 1;
    while (!done8 && m < 4 * W8) begin
      @(negedge clk);
      m++;
    end
    check("b2b_lat", 64'(m), 64'(W8 + 1));
    check("b2b_res", 64'({ovf8, cout8, sum8}), 64'(e));
    @(negedge clk);
    check("b2b_pulse", 64'(done8), 64'd0);

    // asynchronous reset in the middle of a run
    @(negedge clk);
    start8 = 1'b1; sub8 = 1'b0;
    a8 = 8'h3C; b8 = 8'h41; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy8), 64'd0);
    check("arst_done", 64'(done8), 64'd0);
    check("arst_res", 64'({ovf8, cout8, sum8}), 64'd0);
    hits = 0;
    repeat (2) begin
      @(negedge clk);
      if (done8) hits++;
    end
    #3 rst_n = 1'b1;
    repeat (W8 + 2) begin
      @(negedge clk);
      if (done8) hits++;
    end
    check("arst_nodone", 64'(hits), 64'd0);
    last8 = '0;
    op8(1'b0, 8'h01, 8'h01, 1'b0, "post_rst");

    for (int i = 0; i < 512; i++)
      op4(4'(i >> 5), 4'(i >> 1), 1'(i));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
